// File: rtl/id_scoreboard.sv
// Register scoreboard / issue controller between decode and execute.
// Optional macro ID_SCB_WB_BYPASS_EN: hazards see post-writeback counts (regfile forwards wb data).
module id_scoreboard #(
    parameter int unsigned PEND_W    = 2,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid_i,
    input  logic        rs1_r_ena_i,
    input  logic [4:0]  rs1_r_addr_i,
    input  logic        rs2_r_ena_i,
    input  logic [4:0]  rs2_r_addr_i,
    input  logic        rd_w_ena_i,
    input  logic [4:0]  rd_w_addr_i,
    input  logic        ex_ready_i,
    input  logic        wb_ena_i,
    input  logic [4:0]  wb_addr_i,
    input  logic        flush_i,
    output logic        issue_o,
    output logic        stall_o,
    output logic [31:0] busy_vec_o,
    output logic [4:0]  outstanding_o,
    output logic        wb_err_o
);

    localparam int unsigned NREG  = 32;
    localparam int unsigned TOT_W = 5;
    localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};
    localparam logic [TOT_W-1:0]  TOT_LIM = TOT_W'(MAX_OUTST);

    // Entry 0 exists only to make address-0 lookups read as zero; it is never written.
    logic [PEND_W-1:0] cnt_q [NREG];
    logic [PEND_W-1:0] cnt_d [NREG];
    logic [TOT_W-1:0]  tot_q, tot_d;
    logic              wb_err_q, wb_err_d;

    logic              wb_hit, wb_dec, inc, haz;
    logic [PEND_W-1:0] rs1_cnt, rs2_cnt, rd_cnt;
    logic [TOT_W-1:0]  tot_eff;

    assign wb_hit = wb_ena_i && (wb_addr_i != 5'd0);
    assign wb_dec = wb_hit && (cnt_q[wb_addr_i] != '0);

`ifdef ID_SCB_WB_BYPASS_EN
    // Counts as they will be after this cycle's retiring writeback.
    assign rs1_cnt = cnt_q[rs1_r_addr_i] - PEND_W'(wb_dec && (wb_addr_i == rs1_r_addr_i));
    assign rs2_cnt = cnt_q[rs2_r_addr_i] - PEND_W'(wb_dec && (wb_addr_i == rs2_r_addr_i));
    assign rd_cnt  = cnt_q[rd_w_addr_i]  - PEND_W'(wb_dec && (wb_addr_i == rd_w_addr_i));
    assign tot_eff = tot_q - TOT_W'(wb_dec);
`else
    assign rs1_cnt = cnt_q[rs1_r_addr_i];
    assign rs2_cnt = cnt_q[rs2_r_addr_i];
    assign rd_cnt  = cnt_q[rd_w_addr_i];
    assign tot_eff = tot_q;
`endif

    assign haz = (rs1_r_ena_i && (rs1_cnt != '0))
               | (rs2_r_ena_i && (rs2_cnt != '0))
               | (rd_w_ena_i  && (rd_cnt == CNT_MAX))
               | (rd_w_ena_i  && (rd_w_addr_i != 5'd0) && (tot_eff == TOT_LIM));

    assign stall_o = id_valid_i && (haz || !ex_ready_i || flush_i);
    assign issue_o = id_valid_i && !stall_o;
    assign inc     = issue_o && rd_w_ena_i && (rd_w_addr_i != 5'd0);

    // Next-state: flush wins; otherwise apply issue increment and writeback decrement.
    always_comb begin
        cnt_d    = cnt_q;
        tot_d    = tot_q;
        wb_err_d = wb_err_q;
        if (flush_i) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                cnt_d[i] = '0;
            end
            tot_d = '0;
        end else begin
            for (int unsigned i = 1; i < NREG; i++) begin
                cnt_d[i] = cnt_q[i]
                         + PEND_W'(inc    && (rd_w_addr_i == 5'(i)))
                         - PEND_W'(wb_dec && (wb_addr_i   == 5'(i)));
            end
            tot_d = tot_q + TOT_W'(inc) - TOT_W'(wb_dec);
            if (wb_hit && !wb_dec) begin
                wb_err_d = 1'b1;
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
            tot_q    <= '0;
            wb_err_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            tot_q    <= tot_d;
            wb_err_q <= wb_err_d;
        end
    end

    always_comb begin
        busy_vec_o = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            busy_vec_o[i] = |cnt_q[i];
        end
    end

    assign outstanding_o = tot_q;
    assign wb_err_o      = wb_err_q;

endmodule

// File: doc/id_scoreboard.md
# id_scoreboard

Register scoreboard and issue controller between the decode stage and execute. Tracks every architectural register with a write still in flight and decides each cycle whether the decoded instruction may issue. Stalls decode on read-after-write and write-after-write saturation hazards, and releases registers as writebacks retire. Decode presents its read/write enables and addresses; execute presents `ex_ready`; writeback presents its retire port.

## Interface
- `PEND_W`, 2: width of the per-register pending-write counter; max pending per register = 2^PEND_W−1.
- `MAX_OUTST`, 4: max total in-flight writes across all registers (1..31).
- `clk` in 1: core clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: decode holds a valid instruction.
- `rs1_r_ena` in 1, `rs1_r_addr` in 5: decode source 1.
- `rs2_r_ena` in 1, `rs2_r_addr` in 5: decode source 2.
- `rd_w_ena` in 1, `rd_w_addr` in 5: decode destination.
- `ex_ready` in 1: execute can accept an instruction this cycle.
- `wb_ena` in 1, `wb_addr` in 5: writeback retiring a write this cycle.
- `flush` in 1: discard all in-flight writes.
- `issue` out 1: instruction transfers to execute this cycle.
- `stall` out 1: decode must hold its instruction.
- `busy_vec` out 32: bit i set when register i has pending count > 0; bit 0 always 0.
- `outstanding` out 5: total in-flight writes.
- `wb_err` out 1: sticky; a writeback hit a register with zero pending.

## Operation
- State: 31 counters `cnt[1..31]` of PEND_W bits, total counter `tot`, sticky `wb_err`. x0 is never tracked; any access to address 0 is ignored for hazard and counting.
- Hazard `haz` = (rs1_r_ena & cnt[rs1]≠0) | (rs2_r_ena & cnt[rs2]≠0) | (rd_w_ena & cnt[rd]=max) | (rd_w_ena & rd≠0 & tot=MAX_OUTST).
- `stall` = id_valid & (haz | ~ex_ready | flush). `issue` = id_valid & ~stall.
- On `issue` with rd_w_ena and rd≠0: cnt[rd]+1, tot+1.
- On `wb_ena`, wb_addr≠0, cnt[wb_addr]>0: cnt[wb_addr]−1, tot−1. If cnt[wb_addr]=0: no change, set `wb_err`.
- Issue and writeback to same register in one cycle: cnt unchanged, tot unchanged.
- Issue and writeback to different registers: both applied; tot unchanged.
- `flush`: all cnt and tot cleared next edge; same-cycle issue and writeback ignored; `wb_err` kept.
- Counters never wrap: saturation is prevented by stall, not by clamping.
- No state transitions when id_valid=0 except writeback and flush.

## Timing
- Reset (rst_n low, asynchronous): all cnt=0, tot=0, `wb_err`=0; hence `busy_vec`=0, `outstanding`=0; `issue`/`stall` follow inputs combinationally (stall=0 when id_valid=0).
- Release of rst_n is synchronized by the parent; block state first updates on the first rising edge with rst_n high.
- `issue`, `stall` combinational from state and current inputs; zero-cycle decision.
- Issue in cycle N → `busy_vec`/`outstanding` reflect it in N+1.
- Writeback in cycle N → counter decremented in N+1; dependent instruction stalled in N, issues N+1 (without bypass).
- Reset mid-operation drops all pending state; no writeback after reset is expected to match.

## Configuration
- `ID_SCB_WB_BYPASS_EN` defined: a source hazard is suppressed in the cycle a writeback to that register brings its count from 1 to 0 (writeback data forwarded by the regfile); dependent instruction issues same cycle as writeback. The rd saturation and tot checks also use post-writeback values.
- Undefined: hazard uses registered counts only; one bubble after every resolving writeback.

## Test plan
- Reset: rst_n=0 mid-stream with cnt[5]=2 → busy_vec=0, outstanding=0, wb_err=0 immediately.
- RAW: issue addi x5 (rd=5); next cycle decode rs1=5 → stall=1 until wb_addr=5; issue one cycle after wb (same cycle with `ID_SCB_WB_BYPASS_EN`).
- Saturation: issue three writes to x7 with no wb → cnt[7]=3, fourth with rd=7 stalls; wb_addr=7 → issues next cycle.
- Outstanding limit: four writes to x1..x4 → outstanding=4, write to x9 stalls; write with rd_w_ena=0 and no hazard issues.
- Simultaneous: cnt[3]=1, issue rd=3 with wb_addr=3 same cycle → cnt[3]=1, outstanding unchanged.
- Error/flush/x0: wb_addr=6 with cnt[6]=0 → wb_err=1 sticky; rd=0 and rs1=0 never stall; flush with outstanding=3 → outstanding=0 next cycle, wb_err still 1.
